// File: rtl/iter_div_unit.sv
// Multi-cycle restoring divider for the EX-stage DIV opcode.
// One quotient bit per cycle, fixed latency of WIDTH+2 edges from the accepting edge.
module iter_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk1,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [WIDTH-1:0] dreg_q, dreg_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] raw_q, raw_d;
   logic             q_neg_q, q_neg_d;
   logic             r_neg_q, r_neg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             ge;

   always_comb begin
      shifted = {prem_q, dreg_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};
      ge      = (shifted >= {1'b0, dvs_q});

      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      dreg_d  = dreg_q;
      dvs_d   = dvs_q;
      raw_d   = raw_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      done_d  = 1'b0;
      dz_d    = dz_q;
      quo_d   = quo_q;
      rem_d   = rem_q;

      case (state_q)
         S_IDLE: begin
            // The done cycle still counts as busy, so a start seen then is dropped.
            if (start && !done_q) begin
               raw_d   = dividend;
               dreg_d  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
               dvs_d   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
               q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
               r_neg_d = is_signed & dividend[WIDTH-1];
               prem_d  = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            prem_d = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
            dreg_d = {dreg_q[WIDTH-2:0], ge};
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1))
               state_d = S_FIX;
         end
         S_FIX: begin
            // A zero magnitude only arises from a zero divisor.
            if (dvs_q == '0) begin
               quo_d = '1;
               rem_d = raw_q;
               dz_d  = 1'b1;
            end else begin
               quo_d = q_neg_q ? -dreg_q : dreg_q;
               rem_d = r_neg_q ? -prem_q : prem_q;
               dz_d  = 1'b0;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE) || done_d;
   end

   always_ff @(posedge clk1) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         dreg_q  <= '0;
         dvs_q   <= '0;
         raw_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         dreg_q  <= dreg_d;
         dvs_q   <= dvs_d;
         raw_q   <= raw_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Bench for iter_div_unit: vector table + scoreboard queue, plus hold-start and mid-run reset sequences.
module tb_iter_div_unit;

   localparam int W   = 32;
   localparam int LAT = W + 2;

   typedef struct {
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   logic         clk1 = 1'b0;
   logic         reset, start, is_signed;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   iter_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk1(clk1), .reset(reset), .start(start), .is_signed(is_signed),
      .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", n, act, exp);
      end
   endtask

   task automatic model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        output exp_t e);
      if (b == '0) begin
         e.q = '1; e.r = a; e.dz = 1'b1;
      end else if (!s) begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         e.q = a; e.r = '0; e.dz = 1'b0;
      end else begin
         e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.dz = 1'b0;
      end
   endtask

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk1) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
         end
      end
   end

   task automatic wait_done(input string n, input int exp_cnt);
      int cnt = 0;
      bit busy_ok = 1'b1;
      do begin
         @(negedge clk1);
         cnt++;
         if (!done && !busy) busy_ok = 1'b0;
      end while (!done && cnt < 100);
      chk({n, "_latency"}, cnt, exp_cnt);
      chk({n, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
      chk({n, "_busy_at_done"}, {31'd0, busy}, 32'd1);
   endtask

   task automatic do_div(input vec_t v);
      int   cnt = 0;
      exp_t e;
      while ((busy || done) && cnt < 200) begin
         @(negedge clk1);
         cnt++;
      end
      chk("idle_wait", {31'd0, busy | done}, 32'd0);
      start = 1'b1; is_signed = v.s; dividend = v.a; divisor = v.b;
      e.q = v.q; e.r = v.r; e.dz = v.dz;
      sb.push_back(e);
      @(posedge clk1); #1;
      start = 1'b0; is_signed = $urandom; dividend = $urandom; divisor = $urandom;
      wait_done("div", LAT);
      @(negedge clk1);
      chk("done_drop", {31'd0, done}, 32'd0);
      chk("busy_drop", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[$];
      int   seen;
      exp_t e;

      vt.push_back('{1'b0, 32'd20,        32'd4,          32'd5,          32'd0,          1'b0});
      vt.push_back('{1'b1, 32'hFFFF_FFEC, 32'd3,          32'hFFFF_FFFA,  32'hFFFF_FFFE,  1'b0});
      vt.push_back('{1'b0, 32'hFFFF_FFFF, 32'd2,          32'h7FFF_FFFF,  32'd1,          1'b0});
      vt.push_back('{1'b0, 32'd7,         32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1});
      vt.push_back('{1'b1, 32'd7,         32'd0,          32'hFFFF_FFFF,  32'd7,          1'b1});
      vt.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0});
      vt.push_back('{1'b1, 32'd20,        32'hFFFF_FFFD,  32'hFFFF_FFFA,  32'd2,          1'b0});
      vt.push_back('{1'b0, 32'd3,         32'd10,         32'd0,          32'd3,          1'b0});
      vt.push_back('{1'b1, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1});
      vt.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0});
      for (int i = 0; i < 6; i++) begin
         vec_t v;
         v.s = $urandom_range(1);
         v.a = $urandom;
         v.b = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (v.s && i == 4) v.b = -v.b;
         model(v.s, v.a, v.b, e);
         v.q = e.q; v.r = e.r; v.dz = e.dz;
         vt.push_back(v);
      end

      reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_quot", quotient, 32'd0);
      chk("rst_rem", remainder, 32'd0);
      chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
      reset = 1'b0;
      @(negedge clk1);

      foreach (vt[i]) do_div(vt[i]);

      // start held high across the run and the done cycle with new operands on the bus
      start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
      sb.push_back('{32'd14, 32'd2, 1'b0});
      sb.push_back('{32'd3, 32'd0, 1'b0});
      @(posedge clk1); #1;
      dividend = 32'd9; divisor = 32'd3;
      wait_done("hold1", LAT);
      @(negedge clk1);
      chk("hold_idle_gap", {31'd0, busy}, 32'd0);
      @(negedge clk1);
      chk("hold_accept", {31'd0, busy}, 32'd1);
      start = 1'b0;
      wait_done("hold2", LAT - 1);
      @(negedge clk1);

      // reset in the middle of a run discards it
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk1); #1;
      start = 1'b0;
      repeat (10) @(negedge clk1);
      reset = 1'b1;
      @(negedge clk1);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_quot", quotient, 32'd0);
      chk("mid_rst_rem", remainder, 32'd0);
      chk("mid_rst_dz", {31'd0, div_by_zero}, 32'd0);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk1);
         if (done) seen++;
      end
      chk("no_done_after_rst", seen, 0);
      do_div('{1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0});

      repeat (2) @(negedge clk1);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
